// File: rtl/scan_loader.sv
// Byte-wide host loader for a serial scan chain: shifts each byte LSB first and optionally returns the bits clocked out.
// Build option: define SCAN_READBACK_EN to capture scan_return and present it through the out_* handshake.
module scan_loader #(
  parameter int unsigned CHAIN_BYTES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_return,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = (CHAIN_BYTES > 1) ? $clog2(CHAIN_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CHAIN_BYTES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state, state_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
  logic              last_bit;
  logic              in_ready_d, scan_enable_d, scan_in_d, busy_d, frame_done_d;

`ifdef SCAN_READBACK_EN
  logic [BYTE_W-1:0] rdbk_q, rdbk_d;
  logic              out_valid_d;
`endif

  assign last_bit = (bit_cnt == LAST_BIT);

  // State and datapath registers; every output is registered from its look-ahead value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_q      <= '0;
      byte_cnt    <= '0;
      in_ready    <= 1'b1;
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      data_q      <= data_d;
      byte_cnt    <= byte_cnt_d;
      in_ready    <= in_ready_d;
      scan_enable <= scan_enable_d;
      scan_in     <= scan_in_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
    end
  end

`ifdef SCAN_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdbk_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      rdbk_q    <= rdbk_d;
      out_valid <= out_valid_d;
    end
  end

  assign out_data = rdbk_q;
`else
  logic unused_inputs;

  assign out_valid     = 1'b0;
  assign out_data      = '0;
  assign unused_inputs = out_ready ^ scan_return;
`endif

  // Next-state: accept in IDLE, eight shift cycles, then optional hold for readback.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    data_d       = data_q;
    byte_cnt_d   = byte_cnt;
    frame_done_d = 1'b0;
`ifdef SCAN_READBACK_EN
    rdbk_d       = rdbk_q;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          data_d    = in_data;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        bit_cnt_d = BIT_W'(bit_cnt + 1'b1);
`ifdef SCAN_READBACK_EN
        rdbk_d[bit_cnt] = scan_return;
`endif
        if (last_bit) begin
`ifdef SCAN_READBACK_EN
          state_d = HOLD;
`else
          state_d = IDLE;
`endif
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            byte_cnt_d = CNT_W'(byte_cnt + 1'b1);
          end
        end
      end
`ifdef SCAN_READBACK_EN
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output look-ahead decoded from the next state so the flops line up with it.
  always_comb begin
    in_ready_d    = (state_d == IDLE);
    scan_enable_d = (state_d == SHIFT);
    busy_d        = (state_d != IDLE);
    scan_in_d     = 1'b0;
    if (state_d == SHIFT) scan_in_d = data_d[bit_cnt_d];
`ifdef SCAN_READBACK_EN
    out_valid_d   = (state_d == HOLD);
`endif
  end

endmodule

// File: tb/tb_scan_loader.sv
// Scoreboard bench for scan_loader: stimulus queues expected scan/readback bytes, monitors pop and compare.
`timescale 1ns/1ps
module tb_scan_loader;

  localparam int unsigned CHAIN_BYTES = 32;
  localparam int unsigned CHAIN_BITS  = CHAIN_BYTES * 8;
`ifdef SCAN_READBACK_EN
  localparam int PERIOD = 10;
`else
  localparam int PERIOD = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       scan_enable, scan_in, scan_return;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       frame_done, busy;

  scan_loader #(.CHAIN_BYTES(CHAIN_BYTES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_return(scan_return),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int frames = 0;
  int prev_acc = -1;

  logic [7:0] exp_sc[$];
  logic [7:0] exp_rb[$];

  // Chain model (first cell index 0) or a fixed pattern for scan_return
  logic [CHAIN_BITS-1:0] chain = '0;
  logic       chain_clr = 1'b0;
  logic       use_model = 1'b1;
  logic [7:0] pat = 8'h3C;
  logic [2:0] rcnt = 3'd0;

  assign scan_return = use_model ? chain[CHAIN_BITS-1] : pat[rcnt];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rcnt <= scan_enable ? rcnt + 3'd1 : 3'd0;
    if (chain_clr) chain <= '0;
    else if (scan_enable) chain <= {chain[CHAIN_BITS-2:0], scan_in};
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Scan monitor: capture bits while scan_enable, compare the byte once it drops
  int sc_cnt = 0;
  logic [7:0] sc_cap = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      sc_cnt = 0;
    end else if (scan_enable) begin
      if (sc_cnt < 8) sc_cap[sc_cnt[2:0]] = scan_in;
      sc_cnt++;
      chk(busy == 1'b1, "busy_in_shift", int'(busy), 1);
    end else if (sc_cnt != 0) begin
      chk(sc_cnt == 8, "shift_len", sc_cnt, 8);
      chk(scan_in == 1'b0, "scan_in_idle", int'(scan_in), 0);
      if (exp_sc.size() == 0) begin
        chk(1'b0, "scan_unexpected", int'(sc_cap), 0);
      end else begin
        e = exp_sc.pop_front();
        chk(sc_cap == e, "scan_byte", int'(sc_cap), int'(e));
      end
`ifndef SCAN_READBACK_EN
      chk(!out_valid && out_data == 8'h00, "no_readback", int'({out_valid, out_data}), 0);
`endif
      sc_cnt = 0;
    end
  end

`ifdef SCAN_READBACK_EN
  // Readback monitor: compare on each accepted out handshake
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && out_valid && out_ready) begin
      chk(!in_ready, "valid_ready_excl", int'(in_ready), 0);
      if (exp_rb.size() == 0) begin
        chk(1'b0, "rb_unexpected", int'(out_data), 0);
      end else begin
        e = exp_rb.pop_front();
        chk(out_data == e, "rb_byte", int'(out_data), int'(e));
      end
    end
  end
`endif

  always @(negedge clk) if (frame_done) frames++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_chain();
    @(negedge clk);
    chain_clr = 1'b1;
    @(negedge clk);
    chain_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] rb, input bit push, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk(1'b0, "accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    if (push) begin
      exp_sc.push_back(b);
      exp_rb.push_back(rb);
    end
    if (prev_acc >= 0) chk(cyc - prev_acc == PERIOD, "byte_period", cyc - prev_acc, PERIOD);
    prev_acc = hold ? cyc : -1;
    @(posedge clk); #1;
    in_data = ~b;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(!busy, "idle_timeout", int'(busy), 0);
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    int base;
    bit saw;
    logic [7:0] b;

    // Reset state, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    chk(scan_enable == 1'b0, "rst_scan_enable", int'(scan_enable), 0);
    chk(scan_in == 1'b0, "rst_scan_in", int'(scan_in), 0);
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(out_data == 8'h00, "rst_out_data", int'(out_data), 0);
    chk(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // 0xA5 into an empty chain: readback zero
    clear_chain();
    send(8'hA5, 8'h00, 1'b1, 1'b0);
    wait_idle();
    chk(frames == 0, "no_early_frame", frames, 0);

`ifdef SCAN_READBACK_EN
    // Readback of 0x3C held while out_ready low
    use_model = 1'b0;
    out_ready = 1'b0;
    send(8'h5A, 8'h3C, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid == 1'b1, "rb_valid_timeout", int'(out_valid), 1);
    repeat (5) begin
      chk(out_valid && !in_ready && out_data == 8'h3C, "rb_hold",
          int'({out_valid, in_ready, out_data}), int'({2'b10, 8'h3C}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
`endif

    // Full chain: 32 pattern bytes, then 32 zeros push them back out in order
    do_reset();
    use_model = 1'b1;
    clear_chain();
    base = frames;
    prev_acc = -1;
    for (int i = 0; i < 64; i++) begin
      b = (i < 32) ? 8'(i * 37 + 11) : 8'h00;
      send(b, (i < 32) ? 8'h00 : 8'((i - 32) * 37 + 11), 1'b1, i != 63);
      if (i == 31) chk(frames == base, "frame_before_32", frames - base, 0);
      if (i == 33) chk(frames == base + 1, "frame_at_32", frames - base, 1);
    end
    wait_idle();
    chk(frames == base + 2, "frame_at_64", frames - base, 2);

    // Reset in the middle of a shift aborts the byte and restarts the byte count
    do_reset();
    use_model = 1'b0;
    send(8'hC3, 8'h00, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!scan_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk(!scan_enable && !scan_in && !busy && in_ready && !out_valid, "abort_outputs",
        int'({scan_enable, scan_in, busy, in_ready, out_valid}), int'(5'b00010));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk(!saw, "no_rb_after_abort", int'(saw), 0);
    base = frames;
    prev_acc = -1;
    for (int i = 0; i < 32; i++) begin
      send(8'(i + 1), 8'h3C, 1'b1, i != 31);
      if (i == 31) chk(frames == base, "frame_after_abort_early", frames - base, 0);
    end
    wait_idle();
    chk(frames == base + 1, "frame_after_abort", frames - base, 1);

    chk(exp_sc.size() == 0, "scan_queue_drained", exp_sc.size(), 0);
`ifdef SCAN_READBACK_EN
    chk(exp_rb.size() == 0, "rb_queue_drained", exp_rb.size(), 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
